// File: rtl/nonce_range_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nonce_range_scheduler_pkg
// Description : Shared constants, scheduler state encoding and a clog2 helper
// Revision    : 1.0 - initial release
// ============================================================================
package nonce_range_scheduler_pkg;

    localparam int c_NONCE_W_DEF = 32;

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_LATCH    = 3'd1;
    localparam logic [2:0] c_ST_DISPATCH = 3'd2;
    localparam logic [2:0] c_ST_RUN      = 3'd3;
    localparam logic [2:0] c_ST_DONE     = 3'd4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nonce_range_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : nonce_range_scheduler_rr_arbiter
// Description : Round-robin arbiter, one-hot grant, search starts after last grant
// Revision    : 1.0 - initial release
// ============================================================================
module nonce_range_scheduler_rr_arbiter
    import nonce_range_scheduler_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int c_IDX_W = (clog2(N) == 0) ? 1 : clog2(N);

    logic [c_IDX_W-1:0] r_ptr;
    logic [c_IDX_W-1:0] w_cand;
    logic [c_IDX_W-1:0] w_gidx;
    logic               w_hit;

    always_comb begin
        grant  = '0;
        w_hit  = 1'b0;
        w_cand = '0;
        w_gidx = r_ptr;
        for (int k = 0; k < N; k++) begin
            w_cand = c_IDX_W'((int'(r_ptr) + k) % N);
            if (advance && !w_hit && req[w_cand]) begin
                grant[w_cand] = 1'b1;
                w_gidx        = w_cand;
                w_hit         = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_hit) begin
            r_ptr <= c_IDX_W'((int'(w_gidx) + 1) % N);
        end
    end

endmodule
`default_nettype wire

// File: rtl/nonce_range_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : nonce_range_scheduler
// Description : Splits a nonce job across hashing cores and merges their results
// Revision    : 1.0 - initial release
// ============================================================================
module nonce_range_scheduler
    import nonce_range_scheduler_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = c_NONCE_W_DEF
) (
    input  logic                         hash_clk,
    input  logic                         reset,
    input  logic                         new_work,
    input  logic [NONCE_W-1:0]           nonce_min,
    input  logic [NONCE_W-1:0]           nonce_max,
    output logic [NUM_CORES-1:0]         core_start,
    output logic [NUM_CORES*NONCE_W-1:0] core_nonce_min,
    output logic [NUM_CORES*NONCE_W-1:0] core_nonce_max,
    input  logic [NUM_CORES-1:0]         core_found,
    input  logic [NUM_CORES*NONCE_W-1:0] core_golden_nonce,
    input  logic [NUM_CORES-1:0]         core_done,
    output logic [NONCE_W-1:0]           golden_nonce,
    output logic                         new_golden_nonce,
    output logic                         busy,
    output logic                         job_done,
    output logic                         err_range,
    output logic                         overflow
);

    localparam int                 c_LOG2N    = clog2(NUM_CORES);
    localparam int                 c_IDX_W    = (c_LOG2N == 0) ? 1 : c_LOG2N;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_CORES - 1);

    logic [2:0]            r_state;
    logic [NONCE_W-1:0]    r_min, r_max, r_base, r_chunk, r_golden;
    logic [c_IDX_W-1:0]    r_idx, r_last_idx;
    logic [NUM_CORES-1:0]  r_started, r_start, r_start_d, r_pend;
    logic [NONCE_W-1:0]    r_rng_min [NUM_CORES];
    logic [NONCE_W-1:0]    r_rng_max [NUM_CORES];
    logic [NONCE_W-1:0]    r_pend_val[NUM_CORES];
    logic                  r_err, r_ovf, r_new_golden;

    logic [NONCE_W:0]      w_span, w_chunk;
    logic                  w_err, w_launch, w_tgt_last, w_all_done, w_advance;
    logic [c_IDX_W-1:0]    w_last_new, w_last_sel, w_tgt_idx;
    logic [NONCE_W-1:0]    w_tgt_base, w_tgt_chunk, w_tgt_end, w_gval;
    logic [NUM_CORES-1:0]  w_grant;

    // span is one bit wider so a full 2^NONCE_W range does not wrap to zero
    assign w_span     = ({1'b0, r_max} - {1'b0, r_min}) + {{NONCE_W{1'b0}}, 1'b1};
    assign w_chunk    = w_span >> c_LOG2N;
    assign w_err      = (r_max < r_min);
    assign w_last_new = (w_chunk == '0) ? '0 : c_LAST_IDX;

    // One shared accumulator: LATCH launches core 0, DISPATCH launches idx+1
    always_comb begin
        w_launch    = 1'b0;
        w_tgt_idx   = r_idx + 1'b1;
        w_tgt_base  = r_base;
        w_tgt_chunk = r_chunk;
        w_last_sel  = r_last_idx;
        if (r_state == c_ST_LATCH) begin
            w_launch    = !w_err;
            w_tgt_idx   = '0;
            w_tgt_base  = r_min;
            w_tgt_chunk = w_chunk[NONCE_W-1:0];
            w_last_sel  = w_last_new;
        end else if (r_state == c_ST_DISPATCH) begin
            w_launch    = (r_idx != r_last_idx);
        end
        w_tgt_last = (w_tgt_idx == w_last_sel);
        w_tgt_end  = w_tgt_last ? r_max : (w_tgt_base + w_tgt_chunk - 1'b1);
    end

    // done from a core is trusted only two cycles after its start pulse
    always_comb begin
        w_all_done = 1'b1;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (r_started[i] && !(core_done[i] && !r_start[i] && !r_start_d[i]))
                w_all_done = 1'b0;
        end
    end

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_min      <= '0;
            r_max      <= '0;
            r_base     <= '0;
            r_chunk    <= '0;
            r_idx      <= '0;
            r_last_idx <= '0;
            r_started  <= '0;
            r_start    <= '0;
            r_start_d  <= '0;
            r_err      <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_rng_min[i] <= '0;
                r_rng_max[i] <= '0;
            end
        end else if (new_work) begin
            r_state   <= c_ST_LATCH;
            r_min     <= nonce_min;
            r_max     <= nonce_max;
            r_idx     <= '0;
            r_started <= '0;
            r_start   <= '0;
            r_start_d <= '0;
            r_err     <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_rng_min[i] <= '0;
                r_rng_max[i] <= '0;
            end
        end else begin
            r_start_d <= r_start;
            r_start   <= '0;
            case (r_state)
                c_ST_LATCH: begin
                    r_chunk    <= w_chunk[NONCE_W-1:0];
                    r_last_idx <= w_last_new;
                    if (w_err) begin
                        r_err   <= 1'b1;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_state <= c_ST_DISPATCH;
                    end
                end
                c_ST_DISPATCH: if (r_idx == r_last_idx) r_state <= c_ST_RUN;
                c_ST_RUN:      if (w_all_done && (r_pend == '0)) r_state <= c_ST_DONE;
                default:       r_state <= r_state;
            endcase
            if (w_launch) begin
                r_start[w_tgt_idx]   <= 1'b1;
                r_started[w_tgt_idx] <= 1'b1;
                r_rng_min[w_tgt_idx] <= w_tgt_base;
                r_rng_max[w_tgt_idx] <= w_tgt_end;
                r_idx                <= w_tgt_idx;
                r_base               <= w_tgt_base + w_tgt_chunk;
            end
        end
    end

    // Results captured while dispatching are held until RUN, then arbitrated
    assign w_advance = ((r_state == c_ST_RUN) || (r_state == c_ST_DONE)) && !new_work;

    nonce_range_scheduler_rr_arbiter #(
        .N       (NUM_CORES)
    ) u_arb (
        .clk     (hash_clk),
        .rst     (reset),
        .req     (r_pend),
        .advance (w_advance),
        .grant   (w_grant)
    );

    always_comb begin
        w_gval = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_grant[i]) w_gval = w_gval | r_pend_val[i];
        end
    end

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            r_pend       <= '0;
            r_ovf        <= 1'b0;
            r_new_golden <= 1'b0;
            r_golden     <= '0;
            for (int i = 0; i < NUM_CORES; i++) r_pend_val[i] <= '0;
        end else if (new_work) begin
            r_pend       <= '0;
            r_ovf        <= 1'b0;
            r_new_golden <= 1'b0;
        end else begin
            r_new_golden <= |w_grant;
            if (|w_grant) r_golden <= w_gval;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (core_found[i] && r_started[i]) begin
                    r_pend_val[i] <= core_golden_nonce[i*NONCE_W +: NONCE_W];
                    r_pend[i]     <= 1'b1;
                    if (r_pend[i] && !w_grant[i]) r_ovf <= 1'b1;
                end else if (w_grant[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_CORES; g++) begin : g_pack
            assign core_nonce_min[g*NONCE_W +: NONCE_W] = r_rng_min[g];
            assign core_nonce_max[g*NONCE_W +: NONCE_W] = r_rng_max[g];
        end
    endgenerate

    assign core_start       = r_start;
    assign golden_nonce     = r_golden;
    assign new_golden_nonce = r_new_golden;
    assign busy             = (r_state == c_ST_LATCH) || (r_state == c_ST_DISPATCH) ||
                              (r_state == c_ST_RUN);
    assign job_done         = (r_state == c_ST_DONE);
    assign err_range        = r_err;
    assign overflow         = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nonce_range_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_nonce_range_scheduler
// Description : Directed bench for nonce_range_scheduler with a result scoreboard
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nonce_range_scheduler;

    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          new_work;
    logic [31:0]   nonce_min, nonce_max;
    logic [NC-1:0] core_start, core_found, core_done;
    logic [NC*32-1:0] core_nonce_min, core_nonce_max, core_golden_nonce;
    logic [31:0]   golden_nonce;
    logic          new_golden_nonce, busy, job_done, err_range, overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [31:0] exp_val[$];
    int          exp_cyc[$];

    nonce_range_scheduler #(.NUM_CORES(NC), .NONCE_W(32)) dut (
        .hash_clk          (clk),
        .reset             (rst),
        .new_work          (new_work),
        .nonce_min         (nonce_min),
        .nonce_max         (nonce_max),
        .core_start        (core_start),
        .core_nonce_min    (core_nonce_min),
        .core_nonce_max    (core_nonce_max),
        .core_found        (core_found),
        .core_golden_nonce (core_golden_nonce),
        .core_done         (core_done),
        .golden_nonce      (golden_nonce),
        .new_golden_nonce  (new_golden_nonce),
        .busy              (busy),
        .job_done          (job_done),
        .err_range         (err_range),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_job(input logic [31:0] mn, input logic [31:0] mx);
        nonce_min = mn;
        nonce_max = mx;
        new_work  = 1'b1;
        tick(1);
        new_work  = 1'b0;
    endtask

    task automatic push(input logic [31:0] v, input int at);
        exp_val.push_back(v);
        exp_cyc.push_back(at);
    endtask

    // Reference ranges: core i gets min+i*chunk .. min+(i+1)*chunk-1, last active ends at max
    task automatic check_ranges(input string tag, input logic [31:0] mn, input logic [31:0] mx);
        logic [32:0] span, chunk;
        logic [31:0] emin, emax;
        int active;
        span   = {1'b0, mx} - {1'b0, mn} + 33'd1;
        chunk  = span >> 2;
        active = (chunk == 33'd0) ? 1 : NC;
        for (int i = 0; i < NC; i++) begin
            if (i < active) begin
                emin = mn + 32'(i) * chunk[31:0];
                emax = (i == active - 1) ? mx : mn + 32'(i + 1) * chunk[31:0] - 32'd1;
            end else begin
                emin = 32'd0;
                emax = 32'd0;
            end
            check($sformatf("%s_min%0d", tag, i), core_nonce_min[i*32 +: 32], emin);
            check($sformatf("%s_max%0d", tag, i), core_nonce_max[i*32 +: 32], emax);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && new_golden_nonce) begin
            n_checks++;
            assert (exp_val.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_golden observed=%0h expected=none", golden_nonce);
            end
            if (exp_val.size() != 0) begin
                check("golden_val", golden_nonce, exp_val.pop_front());
                check("golden_cyc", cyc, exp_cyc.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; new_work = 1'b0; nonce_min = '0; nonce_max = '0;
        core_found = '0; core_done = '0; core_golden_nonce = '0;
        tick(2);
        check("rst_start", core_start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", job_done, 0);
        check("rst_err", err_range, 0);
        check("rst_ovf", overflow, 0);
        check("rst_gold", golden_nonce, 0);
        check("rst_newg", new_golden_nonce, 0);
        check("rst_rmin", core_nonce_min, 0);
        check("rst_rmax", core_nonce_max, 0);
        rst = 1'b0;
        tick(1);

        // Full 32-bit range across four cores
        start_job(32'h0, 32'hFFFF_FFFF);
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("full_busy_c%0d", c), busy, 1);
            check($sformatf("full_start_c%0d", c), core_start,
                  (c >= 2 && c <= 5) ? (4'b0001 << (c - 2)) : 4'b0000);
            tick(1);
        end
        check_ranges("full", 32'h0, 32'hFFFF_FFFF);
        check("full_min2_lit", core_nonce_min[95:64], 32'h8000_0000);

        // Two simultaneous finds, then a single one
        core_golden_nonce = {32'hBBBB_0003, 32'h0, 32'hAAAA_0001, 32'h0};
        core_found = 4'b1010;
        push(32'hAAAA_0001, cyc + 2);
        push(32'hBBBB_0003, cyc + 3);
        tick(1);
        core_found = '0;
        tick(4);
        core_golden_nonce = {96'h0, 32'h1234_5678};
        core_found = 4'b0001;
        push(32'h1234_5678, cyc + 2);
        tick(1);
        core_found = '0;
        tick(3);

        core_done = 4'hF;
        tick(1);
        check("full_job_done", job_done, 1);
        check("full_busy_off", busy, 0);
        core_done = '0;

        // Uneven split; done held high must be ignored right after the last start
        core_done = 4'hF;
        start_job(32'h100, 32'h10A);
        tick(6);
        check("mid_done_c7", job_done, 0);
        check_ranges("mid", 32'h100, 32'h10A);
        check("mid_max3_lit", core_nonce_max[127:96], 32'h10A);
        tick(1);
        check("mid_done_c8", job_done, 1);
        core_done = '0;

        // Tiny job: only core 0 runs, unstarted cores count as done
        start_job(32'h5, 32'h6);
        check("small_start_c1", core_start, 4'b0000);
        tick(1);
        check("small_start_c2", core_start, 4'b0001);
        tick(1);
        check("small_start_c3", core_start, 4'b0000);
        check("small_busy_c3", busy, 1);
        check_ranges("small", 32'h5, 32'h6);
        core_done = 4'b0001;
        tick(1);
        check("small_done_c4", job_done, 0);
        tick(1);
        check("small_done_c5", job_done, 1);
        check("small_busy_c5", busy, 0);
        core_done = '0;

        // Abort during dispatch; stale finds must never surface
        start_job(32'h0, 32'hFFFF_FFFF);
        tick(1);
        check("abort_start0", core_start, 4'b0001);
        core_golden_nonce = {96'h0, 32'hDEAD_0000};
        core_found = 4'b0001;
        tick(1);
        core_found = '0;
        check("abort_start1", core_start, 4'b0010);
        nonce_min = 32'h1000;
        nonce_max = 32'h1FFF;
        new_work  = 1'b1;
        tick(1);
        new_work = 1'b0;
        check("abort_busy", busy, 1);
        check("abort_latch_start", core_start, 4'b0000);
        core_golden_nonce = {32'h0, 32'hDEAD_0002, 64'h0};
        core_found = 4'b0100;
        tick(1);
        core_found = '0;
        for (int i = 0; i < NC; i++) begin
            check($sformatf("redisp_start%0d", i), core_start, 4'b0001 << i);
            tick(1);
        end
        check("redisp_idle", core_start, 4'b0000);
        check_ranges("redisp", 32'h1000, 32'h1FFF);
        tick(4);

        core_golden_nonce = {32'h0, 32'hCAFE_0002, 64'h0};
        core_found = 4'b0100;
        push(32'hCAFE_0002, cyc + 2);
        tick(1);
        core_found = '0;
        tick(3);

        // Overwrite of a still-pending result raises overflow
        check("ovf_clear", overflow, 0);
        core_golden_nonce = {64'h0, 32'h1111_0001, 32'h1111_0000};
        core_found = 4'b0011;
        push(32'h1111_0000, cyc + 2);
        tick(1);
        core_golden_nonce = {64'h0, 32'h2222_0001, 32'h0};
        core_found = 4'b0010;
        push(32'h2222_0001, cyc + 2);
        tick(1);
        core_found = '0;
        tick(3);
        check("ovf_set", overflow, 1);

        // Inverted range
        start_job(32'h10, 32'hF);
        check("err_busy_c1", busy, 1);
        check("err_flag_c1", err_range, 0);
        check("err_ovf_cleared", overflow, 0);
        check("err_start_c1", core_start, 4'b0000);
        tick(1);
        check("err_flag_c2", err_range, 1);
        check("err_done_c2", job_done, 1);
        check("err_busy_c2", busy, 0);
        check("err_start_c2", core_start, 4'b0000);
        check("err_rmin", core_nonce_min, 0);
        tick(1);
        check("err_start_c3", core_start, 4'b0000);

        // Asynchronous reset in the middle of a run
        start_job(32'h0, 32'hFFFF);
        tick(8);
        check("rr_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("rr_busy0", busy, 0);
        check("rr_gold0", golden_nonce, 0);
        check("rr_start0", core_start, 0);
        check("rr_rmin0", core_nonce_min, 0);
        check("rr_rmax0", core_nonce_max, 0);
        check("rr_done0", job_done, 0);
        check("rr_flags0", {err_range, overflow, new_golden_nonce}, 3'b000);
        tick(1);
        rst = 1'b0;
        tick(2);
        check("post_rst_busy", busy, 0);

        tick(3);
        check("sb_empty", exp_val.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
